// File: rtl/ws2812_rx_decoder_pkg.sv
// Shared types and timing defaults for the single-wire GRB LED receiver.
package ws2812_rx_decoder_pkg;

  typedef enum logic [2:0] {SYNC, IDLE, HIGH, LOW, ERR} state_t;

  localparam int unsigned PIX_BITS       = 24;
  localparam int unsigned CNT_W          = 13;
  localparam int unsigned T_THRESH_DEF   = 60;
  localparam int unsigned T_MAX_HIGH_DEF = 150;
  localparam int unsigned T_LATCH_DEF    = 5000;
  localparam int unsigned IDX_W_DEF      = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ws2812_rx_decoder_if.sv
// Decoded-pixel output bundle of the GRB receiver (decoder drives master side).
interface ws2812_rx_decoder_if
  import ws2812_rx_decoder_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF
);
  logic [PIX_BITS-1:0] pix_data;
  logic                pix_valid;
  logic [IDX_W-1:0]    pix_idx;
  logic                frame_done;
  logic                bit_err;
  logic                busy;
  logic                dout;

  modport master (output pix_data, pix_valid, pix_idx, frame_done, bit_err, busy, dout);
  modport slave  (input  pix_data, pix_valid, pix_idx, frame_done, bit_err, busy, dout);
endinterface

// File: rtl/ws2812_rx_decoder_din_sync.sv
// Two-flop synchronizer for the async serial line plus rise/fall pulses on the synced level.
module ws2812_rx_decoder_din_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);
  logic meta;
  logic din_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      meta  <= din;
      din_s <= meta;
      din_d <= din_s;
    end
  end

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;
endmodule

// File: rtl/ws2812_rx_decoder.sv
// GRB LED stream receiver: pulse-width bit slicing, 24-bit pixel assembly, latch detection.
// Optional repeater output enabled by defining WS_FORWARD_EN.
module ws2812_rx_decoder
  import ws2812_rx_decoder_pkg::*;
#(
  parameter int unsigned T_THRESH   = T_THRESH_DEF,
  parameter int unsigned T_MAX_HIGH = T_MAX_HIGH_DEF,
  parameter int unsigned T_LATCH    = T_LATCH_DEF,
  parameter int unsigned IDX_W      = IDX_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  ws2812_rx_decoder_if.master bus
);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0] MAXH   = CNT_W'(T_MAX_HIGH);
  localparam logic [CNT_W-1:0] LATCH  = CNT_W'(T_LATCH);
  localparam logic [4:0]       LAST   = 5'(PIX_BITS - 1);

  logic din_s, rise, fall;
  state_t state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_inc;
  logic                lat_hit, max_hit;
  logic                busy_c, shift_en, frame_end, err_entry, err_exit, bit_v;
  logic [PIX_BITS-1:0] shreg, shreg_n, pix_data_q;
  logic [4:0]          bit_cnt;
  logic [IDX_W-1:0]    pix_idx_q;
  logic                pix_valid_q, frame_done_q, bit_err_q;

  ws2812_rx_decoder_din_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .din_s(din_s),
    .rise (rise),
    .fall (fall)
  );

  assign cnt_inc = sat_inc(cnt);
  assign lat_hit = (cnt_inc >= LATCH);
  assign max_hit = (cnt_inc >= MAXH);

  always_ff @(posedge clk) begin
    if (reset) state <= SYNC;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      SYNC:    if (!din_s && lat_hit) state_n = IDLE;
      IDLE:    if (rise) state_n = HIGH;
      HIGH:    if (fall) state_n = LOW; else if (max_hit) state_n = ERR;
      LOW:     if (rise) state_n = HIGH; else if (lat_hit) state_n = IDLE;
      ERR:     if (!din_s && lat_hit) state_n = IDLE;
      default: state_n = SYNC;
    endcase
  end

  always_comb begin
    busy_c    = (state == HIGH) || (state == LOW);
    shift_en  = (state == HIGH) && fall;
    frame_end = (state == LOW) && !rise && lat_hit;
    err_entry = (state == HIGH) && !fall && max_hit;
    err_exit  = (state == ERR) && !din_s && lat_hit;
    bit_v     = (cnt >= THRESH);
    shreg_n   = {shreg[PIX_BITS-2:0], bit_v};
  end

  // One timer serves as low-run counter (SYNC/ERR/LOW) and high-pulse width (HIGH).
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      unique case (state)
        SYNC, ERR: cnt <= din_s ? '0 : cnt_inc;
        IDLE:      cnt <= rise ? CNT_W'(1) : '0;
        default:   cnt <= (rise || fall) ? CNT_W'(1) : cnt_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      pix_data_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_idx_q    <= '0;
      frame_done_q <= 1'b0;
      bit_err_q    <= 1'b0;
    end else begin
      pix_valid_q  <= 1'b0;
      frame_done_q <= frame_end;
      bit_err_q    <= err_entry || (frame_end && bit_cnt != '0);
      // Index is presented with the pixel, then advanced the cycle after.
      if (pix_valid_q && pix_idx_q != '1) pix_idx_q <= pix_idx_q + IDX_W'(1);
      if (shift_en) begin
        shreg <= shreg_n;
        if (bit_cnt == LAST) begin
          pix_data_q  <= shreg_n;
          pix_valid_q <= 1'b1;
          bit_cnt     <= '0;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
      if (frame_end || err_entry) bit_cnt   <= '0;
      if (frame_end || err_exit)  pix_idx_q <= '0;
    end
  end

  assign bus.pix_data   = pix_data_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_idx    = pix_idx_q;
  assign bus.frame_done = frame_done_q;
  assign bus.bit_err    = bit_err_q;
  assign bus.busy       = busy_c;

`ifdef WS_FORWARD_EN
  logic fwd_q;

  always_ff @(posedge clk) begin
    if (reset)                             fwd_q <= 1'b0;
    else if (frame_end || err_entry)       fwd_q <= 1'b0;
    else if (shift_en && bit_cnt == LAST)  fwd_q <= 1'b1;
  end

  assign bus.dout = fwd_q && busy_c && din_s;
`else
  assign bus.dout = 1'b0;
`endif
endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Scoreboard bench for the GRB LED receiver: directed pulse trains, queued expectations.
module tb_ws2812_rx_decoder;

  typedef struct packed {
    logic [23:0] data;
    logic [3:0]  idx;
  } pix_t;

  typedef struct packed {
    logic fd;
    logic be;
  } evt_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;

  always #5 clk = ~clk;

  ws2812_rx_decoder_if #(.IDX_W(4)) bus ();

  ws2812_rx_decoder #(
    .T_THRESH  (60),
    .T_MAX_HIGH(150),
    .T_LATCH   (5000),
    .IDX_W     (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .bus  (bus)
  );

  int   passed = 0;
  int   total = 0;
  pix_t exp_pix[$];
  evt_t exp_evt[$];
  logic [3:0] exp_idx = '0;
  pix_t pe;
  evt_t ee;
  time  last_err_t = 0;
  logic win = 1'b0;
  logic dout_seen = 1'b0;
  int   dout_hi = 0;
  time  dout_t = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.pix_valid) begin
      if (exp_pix.size() == 0) begin
        total++;
        $display("FAIL pix_unexpected: got data 0x%06h idx %0d, expected no pixel", bus.pix_data, bus.pix_idx);
      end else begin
        pe = exp_pix.pop_front();
        chk("pix_data", 32'(bus.pix_data), 32'(pe.data));
        chk("pix_idx", 32'(bus.pix_idx), 32'(pe.idx));
      end
    end
    if (bus.bit_err) last_err_t = $time;
    if (bus.frame_done || bus.bit_err) begin
      if (exp_evt.size() == 0) begin
        total++;
        $display("FAIL evt_unexpected: got frame_done %0b bit_err %0b, expected none", bus.frame_done, bus.bit_err);
      end else begin
        ee = exp_evt.pop_front();
        chk("frame_done", 32'(bus.frame_done), 32'(ee.fd));
        chk("bit_err", 32'(bus.bit_err), 32'(ee.be));
      end
    end
    if (win && bus.dout) begin
      dout_hi++;
      if (!dout_seen) begin
        dout_seen = 1'b1;
        dout_t = $time;
      end
    end
  end

  task automatic set_din(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_raw(input int hi, input int lo);
    set_din(1'b1, hi);
    set_din(1'b0, lo);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_raw(80, 45);
    else   send_raw(40, 85);
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic push_pix(input logic [23:0] p);
    exp_pix.push_back('{data: p, idx: exp_idx});
    if (exp_idx != 4'hF) exp_idx = exp_idx + 4'd1;
  endtask

  task automatic send_pixel(input logic [23:0] p, input bit expect_it);
    if (expect_it) push_pix(p);
    send_bits(p, 24);
  endtask

  task automatic latch(input bit partial);
    exp_evt.push_back('{fd: 1'b1, be: partial});
    exp_idx = '0;
    set_din(1'b0, 5100);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pix_data"}, 32'(bus.pix_data), 32'h0);
    chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 32'h0);
    chk({tag, "_pix_idx"}, 32'(bus.pix_idx), 32'h0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'h0);
    chk({tag, "_bit_err"}, 32'(bus.bit_err), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_dout"}, 32'(bus.dout), 32'h0);
  endtask

  initial begin
    time t0;
    int  exp_hi;
    logic [23:0] p1;

    // reset, SYNC settle, single pixel
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    reset = 1'b0;
    set_din(1'b0, 5100);
    send_pixel(24'hFF0055, 1'b1);
    latch(1'b0);

    // three-pixel frame, index sequence, hold after frame end
    send_pixel(24'h010203, 1'b1);
    send_pixel(24'h0A0B0C, 1'b1);
    send_pixel(24'hFFFFFF, 1'b1);
    latch(1'b0);
    chk("pix_data_hold", 32'(bus.pix_data), 32'hFFFFFF);

    // threshold boundary: 59 -> 0, 60 -> 1; then overlong pulse mid-pixel
    push_pix(24'h000FFF);
    for (int i = 0; i < 12; i++) send_raw(59, 66);
    for (int i = 0; i < 12; i++) send_raw(60, 65);
    send_bits(24'h0002A5, 10);
    chk("busy_mid_pixel", 32'(bus.busy), 32'h1);
    exp_evt.push_back('{fd: 1'b0, be: 1'b1});
    t0 = $time;
    set_din(1'b1, 200);
    chk("err_latency", 32'(last_err_t - t0), 32'd1520);
    chk("busy_in_err", 32'(bus.busy), 32'h0);
    exp_idx = '0;
    set_din(1'b0, 5100);
    send_pixel(24'h123456, 1'b1);
    latch(1'b0);

    // partial pixel at latch, then reset mid-pixel
    send_bits(24'h000ABC, 12);
    latch(1'b1);
    send_bits(24'h0003FF, 10);
    reset = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("midreset");
    reset = 1'b0;
    exp_idx = '0;
    set_din(1'b0, 100);
    send_bits(24'h0000C3, 8);
    set_din(1'b0, 5100);

    // two-pixel frame with repeater window
    p1 = 24'h3C3C3C;
    win = 1'b1;
    send_pixel(24'hA5A5A5, 1'b1);
    t0 = $time;
    send_pixel(p1, 1'b1);
    latch(1'b0);
    win = 1'b0;
    exp_hi = 0;
`ifdef WS_FORWARD_EN
    for (int i = 0; i < 24; i++) exp_hi += p1[i] ? 80 : 40;
    chk("dout_first_rise_delay", 32'(dout_t - t0), 32'd20);
`endif
    chk("dout_high_cycles", 32'(dout_hi), 32'(exp_hi));

    repeat (10) @(negedge clk);
    chk("pix_queue_left", 32'(exp_pix.size()), 32'd0);
    chk("evt_queue_left", 32'(exp_evt.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
